mem_arbiter: RTL

//  Sequences the single byte-wide RAM/IO port of riscv_top between two requesters:

---
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port sequencer for IF line reads and LSU accesses.
// Optional IO write back-pressure: define MEM_ARBITER_IO_STALL_EN.
module mem_arbiter #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_line,
  input  logic                    lsu_req,
  input  logic                    lsu_wr,
  input  logic [1:0]              lsu_size,
  input  logic [ADDR_W-1:0]       lsu_addr,
  input  logic [31:0]             lsu_wdata,
  output logic                    lsu_done,
  output logic [31:0]             lsu_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int LB_W  = $clog2(LINE_BYTES);
  localparam int CNT_W = LB_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_RD,
    S_LSU_RD,
    S_LSU_WR,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_len;
  logic                    r_last_if;
  logic [31:0]             r_wdata;
  logic [8*LINE_BYTES-1:0] r_buf;
  logic [ADDR_W-1:0]       r_mem_a;
  logic [7:0]              r_mem_dout;
  logic                    r_mem_wr;
  logic                    r_if_done;
  logic                    r_lsu_done;
  logic [8*LINE_BYTES-1:0] r_if_line;
  logic [31:0]             r_lsu_rdata;

  logic                    w_if_ok;
  logic                    w_lsu_ok;
  logic                    w_pick_if;
  logic                    w_pick_lsu;
  logic [CNT_W-1:0]        w_lsu_len;
  logic [ADDR_W-1:0]       w_if_base;
  logic [LB_W-1:0]         w_idx;
  logic [8*LINE_BYTES-1:0] w_buf;
  logic                    w_stall;
  logic                    w_unused;

  // Reads are speculative and blocked by flush; stores are committed.
  assign w_if_ok    = if_req & ~flush;
  assign w_lsu_ok   = lsu_req & (lsu_wr | ~flush);
  assign w_pick_if  = w_if_ok & (~w_lsu_ok | ~r_last_if);
  assign w_pick_lsu = w_lsu_ok & ~w_pick_if;

  always_comb begin
    w_lsu_len = CNT_W'(4);
    unique case (1'b1)
      lsu_size == 2'b00: w_lsu_len = CNT_W'(1);
      lsu_size == 2'b01: w_lsu_len = CNT_W'(2);
      default:           w_lsu_len = CNT_W'(4);
    endcase
  end

  assign w_if_base = {if_addr[ADDR_W-1:LB_W], {LB_W{1'b0}}};
  assign w_idx     = r_cnt[LB_W-1:0] - 1'b1;

  // Byte captured this cycle belongs to the beat issued one cycle earlier.
  always_comb begin
    w_buf = r_buf;
    w_buf[8*w_idx +: 8] = mem_din;
  end

`ifdef MEM_ARBITER_IO_STALL_EN
  assign w_stall = (r_state == S_LSU_WR) &
                   (r_mem_a[17:16] == 2'b11) &
                   io_buffer_full;
`else
  assign w_stall = 1'b0;
`endif

  assign w_unused = ^{io_buffer_full, if_addr[LB_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_last_if   <= 1'b1;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_mem_a     <= '0;
      r_mem_dout  <= '0;
      r_mem_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_lsu_done  <= 1'b0;
      r_if_line   <= '0;
      r_lsu_rdata <= '0;
    end else begin
      r_if_done  <= 1'b0;
      r_lsu_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_buf <= '0;
          if (w_pick_if) begin
            r_state   <= S_IF_RD;
            r_last_if <= 1'b1;
            r_len     <= CNT_W'(LINE_BYTES);
            r_mem_a   <= w_if_base;
          end else if (w_pick_lsu) begin
            r_last_if <= 1'b0;
            r_len     <= w_lsu_len;
            r_mem_a   <= lsu_addr;
            r_wdata   <= lsu_wdata;
            if (lsu_wr) begin
              r_state    <= S_LSU_WR;
              r_mem_wr   <= 1'b1;
              r_mem_dout <= lsu_wdata[7:0];
            end else begin
              r_state <= S_LSU_RD;
            end
          end
        end
        S_IF_RD, S_LSU_RD: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt < r_len - 1'b1)
              r_mem_a <= r_mem_a + 1'b1;
            if (r_cnt != '0)
              r_buf <= w_buf;
            if (r_cnt == r_len) begin
              r_state <= S_DONE;
              if (r_state == S_IF_RD) begin
                r_if_done <= 1'b1;
                r_if_line <= w_buf;
              end else begin
                r_lsu_done  <= 1'b1;
                r_lsu_rdata <= w_buf[31:0];
              end
            end
          end
        end
        S_LSU_WR: begin
          if (!w_stall) begin
            if (r_cnt == r_len - 1'b1) begin
              r_state    <= S_DONE;
              r_mem_wr   <= 1'b0;
              r_lsu_done <= 1'b1;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_mem_a    <= r_mem_a + 1'b1;
              r_mem_dout <= r_wdata[15:8];
              r_wdata    <= r_wdata >> 8;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_done   = r_if_done;
  assign if_line   = r_if_line;
  assign lsu_done  = r_lsu_done;
  assign lsu_rdata = r_lsu_rdata;
  assign mem_dout  = r_mem_dout;
  assign mem_a     = r_mem_a;
  assign mem_wr    = r_mem_wr & ~w_stall;

endmodule
